func_sweep_ctrl: RTL and testbench

- Sequencer/checker that drives the 4-input dual-rail transistor-level `func` cell.
- Steps through all 16 input vectors, holding each for a settle window, then samples the cell output.
- Compares each sample against a 16-bit expected truth table and reports pass/fail plus a per-vector mismatch mask.
- Sits between the self-test control logic and the `func` instance.

---
 rtl/func_sweep_pkg.sv | 19 +
 rtl/func_sweep_ctrl_dual_rail_drv.sv | 23 ++
 rtl/func_sweep_ctrl.sv | 162 ++++++++++++++++
 tb/tb_func_sweep_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/func_sweep_pkg.sv
// Shared types and sizes for the func cell sweep controller.
// Build option: FUNC_SWEEP_STEP_MODE_EN enables single-step HOLD between vectors.
package func_sweep_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int VEC_W       = 4;
  localparam int CNT_W       = 8;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/func_sweep_ctrl_dual_rail_drv.sv
// Dual-rail input driver: one flop per rail pair, complement taken from that same flop
// so a rail can never equal its complement, including while reset is applied.
module dual_rail_drv
  import func_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [VEC_W-1:0] vec_d_i,
  output logic [VEC_W-1:0] rail_t_o,
  output logic [VEC_W-1:0] rail_n_o
);

  logic [VEC_W-1:0] rail_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rail_q <= '0;
    else     rail_q <= vec_d_i;
  end

  assign rail_t_o = rail_q;
  assign rail_n_o = ~rail_q;

endmodule

// File: rtl/func_sweep_ctrl.sv
// Sweeps all 16 input vectors of the func cell and checks its output against a truth table.
// Build option: FUNC_SWEEP_STEP_MODE_EN adds the step input and the HOLD state.
//
// state  | meaning
// IDLE   | waiting for start, results held, rails at vector 0
// SETTLE | current vector driven, counting down the settle window
// SAMPLE | compare func_out against the expected bit, then advance
// DONE   | one-cycle done pulse, pass valid
// HOLD   | (step mode only) vector held until step
module func_sweep_ctrl
  import func_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef FUNC_SWEEP_STEP_MODE_EN
  input  logic        step,
`endif
  input  logic [15:0] expected_tt,
  input  logic        func_out,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        a_n,
  output logic        b_n,
  output logic        c_n,
  output logic        d_n,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mismatch_mask,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail_idx,
  output logic [3:0]  vec_idx
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic [NUM_VECTORS-1:0] tt_q, tt_d;
  logic [NUM_VECTORS-1:0] mask_q, mask_d;
  logic [4:0]             fcnt_q, fcnt_d;
  logic [VEC_W-1:0]       ffi_q, ffi_d;
  logic                   pass_q, pass_d;
  logic                   mis;
  logic [VEC_W-1:0]       rail_t, rail_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      tt_q    <= '0;
      mask_q  <= '0;
      fcnt_q  <= '0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      tt_q    <= tt_d;
      mask_q  <= mask_d;
      fcnt_q  <= fcnt_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    tt_d    = tt_q;
    mask_d  = mask_q;
    fcnt_d  = fcnt_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;
    mis     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tt_d    = expected_tt;
          mask_d  = '0;
          fcnt_d  = '0;
          ffi_d   = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_SAMPLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_SAMPLE: begin
        // X/Z on the cell output must count as a failure, hence the case inequality
        mis = (func_out !== tt_q[vec_q]);
        if (mis) begin
          mask_d[vec_q] = 1'b1;
          fcnt_d        = fcnt_q + 5'd1;
          if (fcnt_q == '0) ffi_d = vec_q;
        end
        if (vec_q == LAST_VEC) begin
          // pass is made valid in the same cycle as the done pulse
          pass_d  = (fcnt_d == '0);
          state_d = ST_DONE;
        end else begin
`ifdef FUNC_SWEEP_STEP_MODE_EN
          state_d = ST_HOLD;
`else
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
`endif
        end
      end
      ST_DONE: begin
        vec_d   = '0;
        state_d = ST_IDLE;
      end
      ST_HOLD: begin
`ifdef FUNC_SWEEP_STEP_MODE_EN
        if (step) begin
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Rails load from the next vector index so they track vec_idx with no extra lag
  dual_rail_drv u_drv (
    .clk      (clk),
    .rst      (rst),
    .vec_d_i  (vec_d),
    .rail_t_o (rail_t),
    .rail_n_o (rail_n)
  );

  assign {a, b, c, d}         = rail_t;
  assign {a_n, b_n, c_n, d_n} = rail_n;
  assign busy                 = (state_q != ST_IDLE);
  assign done                 = (state_q == ST_DONE);
  assign pass                 = pass_q;
  assign mismatch_mask        = mask_q;
  assign fail_count           = fcnt_q;
  assign first_fail_idx       = ffi_q;
  assign vec_idx              = vec_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Self-checking bench for func_sweep_ctrl with a behavioural func cell stub.
module tb_func_sweep_ctrl;

  localparam int S    = 4;
  localparam int PER  = S + 1;
  localparam int DLAT = 16 * PER + 1;

  logic        clk, rst, start, func_out;
  logic [15:0] expected_tt;
  logic        a, b, c, d, a_n, b_n, c_n, d_n;
  logic        busy, done, pass;
  logic [15:0] mismatch_mask;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail_idx, vec_idx;

  logic [15:0] stub_tt;
  logic        stub_z;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] got_mask;
  logic [4:0]  got_cnt;
  logic [3:0]  got_ffi;
  logic        got_pass;

  typedef struct {
    string       name;
    logic [15:0] tt;
    logic [15:0] stub;
    logic [15:0] exp_mask;
    logic [4:0]  exp_cnt;
    logic [3:0]  exp_ffi;
    logic        exp_pass;
  } vec_t;

  vec_t tbl[6];

  func_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .expected_tt    (expected_tt),
    .func_out       (func_out),
    .a              (a),
    .b              (b),
    .c              (c),
    .d              (d),
    .a_n            (a_n),
    .b_n            (b_n),
    .c_n            (c_n),
    .d_n            (d_n),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_mask  (mismatch_mask),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .vec_idx        (vec_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    func_out = stub_tt[{a, b, c, d}];
    if (stub_z) func_out = 1'bz;
  end

  always @(negedge clk) begin
    n_cmp++;
    if ({a, b, c, d} !== ~{a_n, b_n, c_n, d_n}) begin
      n_fail++;
      $display("FAIL rail_invariant: true=%b comp=%b", {a, b, c, d}, {a_n, b_n, c_n, d_n});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Result of a sweep from the rule "mismatch when the cell output is not identical to the expected bit"
  task automatic model(input logic [15:0] tt, input logic [15:0] stub, input bit zm,
                       output logic [15:0] m, output logic [4:0] cnt,
                       output logic [3:0] ffi, output logic p);
    logic fo;
    m = '0; cnt = '0; ffi = '0;
    for (int i = 0; i < 16; i++) begin
      fo = stub[i];
      if (zm) fo = 1'bz;
      if (fo !== tt[i]) begin
        if (cnt == 0) ffi = 4'(i);
        m[i] = 1'b1;
        cnt++;
      end
    end
    p = (m == 16'h0);
  endtask

  task automatic run_sweep(input string nm, input logic [15:0] tt, input logic [15:0] stub,
                           input bit zm, input int pulse_at);
    int n, done_n, exp_v;
    bit rails_ok;
    logic [15:0] em;
    logic [4:0]  ec;
    logic [3:0]  ef;
    logic        ep;
    model(tt, stub, zm, em, ec, ef, ep);
    @(negedge clk);
    expected_tt = tt; stub_tt = stub; stub_z = zm; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    expected_tt = ~tt;
    chk({nm, " busy_after_start"}, 32'(busy), 32'd1);
    n = 1; done_n = 0; rails_ok = 1'b1;
    while (n <= DLAT + 20 && done_n == 0) begin
      exp_v = (n - 1) / PER;
      if (exp_v > 15) exp_v = 15;
      if (vec_idx !== 4'(exp_v) || {a, b, c, d} !== 4'(exp_v) || busy !== 1'b1) rails_ok = 1'b0;
      if (done) begin
        done_n = n;
        got_mask = mismatch_mask; got_cnt = fail_count; got_ffi = first_fail_idx; got_pass = pass;
      end else begin
        start = (n == pulse_at);
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    chk({nm, " done_latency"}, 32'(done_n), 32'(DLAT));
    chk({nm, " rail_sequence"}, 32'(rails_ok), 32'd1);
    chk({nm, " mask"}, 32'(got_mask), 32'(em));
    chk({nm, " fail_count"}, 32'(got_cnt), 32'(ec));
    chk({nm, " first_fail_idx"}, 32'(got_ffi), 32'(ef));
    chk({nm, " pass"}, 32'(got_pass), 32'(ep));
    if (done_n == 0) return;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({nm, " idle_after_done"}, {busy, done, vec_idx, a, b, c, d},
          {1'b0, 1'b0, 4'h0, 4'h0});
    end
    chk({nm, " results_held"}, {mismatch_mask, fail_count, first_fail_idx, pass},
        {em, ec, ef, ep});
  endtask

  initial begin
    int n, t1, t2;
    bit hit;
    logic [15:0] rt, rf;
    tbl[0] = '{"match_a5c3",  16'hA5C3, 16'hA5C3,          16'h0000, 5'd0,  4'd0,  1'b1};
    tbl[1] = '{"flip_5_10",   16'hA5C3, 16'hA5C3 ^ 16'h0420, 16'h0420, 5'd2,  4'd5,  1'b0};
    tbl[2] = '{"all_wrong",   16'h0000, 16'hFFFF,          16'hFFFF, 5'd16, 4'd0,  1'b0};
    tbl[3] = '{"ends_wrong",  16'h8001, 16'h0000,          16'h8001, 5'd2,  4'd0,  1'b0};
    tbl[4] = '{"one_at_2",    16'h1234, 16'h1230,          16'h0004, 5'd1,  4'd2,  1'b0};
    tbl[5] = '{"last_only",   16'hFFFF, 16'h7FFF,          16'h8000, 5'd1,  4'd15, 1'b0};

    rst = 1'b1; start = 1'b0; expected_tt = 16'h0; stub_tt = 16'h0; stub_z = 1'b0;
    #12;
    chk("reset_rails", {a, b, c, d, a_n, b_n, c_n, d_n}, 8'h0F);
    chk("reset_status", {busy, done, pass, vec_idx, fail_count, first_fail_idx},
        {3'b000, 4'h0, 5'h0, 4'h0});
    chk("reset_mask", 32'(mismatch_mask), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_sweep(tbl[i].name, tbl[i].tt, tbl[i].stub, 1'b0, 0);
      chk({tbl[i].name, " tbl_mask"}, 32'(got_mask), 32'(tbl[i].exp_mask));
      chk({tbl[i].name, " tbl_cnt"}, 32'(got_cnt), 32'(tbl[i].exp_cnt));
      chk({tbl[i].name, " tbl_ffi"}, 32'(got_ffi), 32'(tbl[i].exp_ffi));
      chk({tbl[i].name, " tbl_pass"}, 32'(got_pass), 32'(tbl[i].exp_pass));
    end

    run_sweep("z_out", 16'hA5C3, 16'h0000, 1'b1, 0);

    for (int r = 0; r < 4; r++) begin
      rt = 16'($urandom);
      rf = 16'($urandom) & 16'($urandom) & 16'($urandom);
      run_sweep("random", rt, rt ^ rf, 1'b0, 0);
    end

    run_sweep("start_while_busy", 16'hA5C3, 16'hA5C3 ^ 16'h0420, 1'b0, 10);

    // reset when vector 7 is on the rails, mid-cycle
    @(negedge clk);
    expected_tt = 16'hA5C3; stub_tt = 16'h5A3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (vec_idx == 4'd7) hit = 1'b1;
      else @(negedge clk);
    end
    chk("reach_vec7", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midsweep_reset_rails", {a, b, c, d, a_n, b_n, c_n, d_n}, 8'h0F);
    chk("midsweep_reset_status", {busy, done, pass, vec_idx, fail_count, first_fail_idx, mismatch_mask},
        {3'b000, 4'h0, 5'h0, 4'h0, 16'h0});
    @(negedge clk);
    rst = 1'b0;
    run_sweep("after_reset", 16'hA5C3, 16'hA5C3, 1'b0, 0);

    // start held high: back-to-back sweeps
    @(negedge clk);
    expected_tt = 16'hA5C3; stub_tt = 16'hA5C3; start = 1'b1;
    n = 0; t1 = -1; t2 = -1;
    while (n < 400 && t2 < 0) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (t1 < 0) t1 = n;
        else t2 = n;
      end
    end
    start = 1'b0;
    chk("held_start_gap", 32'(t2 - t1), 32'(DLAT + 1));
    chk("held_start_first", 32'(t1), 32'(DLAT));
    n = 0;
    while (n < 200 && busy) begin
      @(negedge clk);
      n++;
    end
    chk("held_start_drain", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
